// File: rtl/disp_7seg_mux_if.sv
// Host-side bundle for the multiplexed sensor display: conversion request,
// status/result, and the shared segment bus with its digit enables.
interface disp_7seg_mux_if #(
  parameter int DIGITS = 4
);
  logic                start;
  logic [1:0]          mode;
  logic [15:0]         data_in;
  logic                busy;
  logic                done;
  logic                error;
  logic signed [15:0]  value_x10;
  logic [7:0]          seg_out;
  logic [DIGITS-1:0]   an_out;

  // Requester side: issues start/mode/data and observes the display.
  modport master (
    output start, mode, data_in,
    input  busy, done, error, value_x10, seg_out, an_out
  );

  // Display controller side.
  modport slave (
    input  start, mode, data_in,
    output busy, done, error, value_x10, seg_out, an_out
  );
endinterface

// File: rtl/disp_7seg_mux.sv
// Sensor display controller: scales a raw 16-bit SHT4x sample to tenths of
// RH %, deg F or deg C, converts the magnitude to BCD one shift-add-3 step per
// cycle, and scans the result over DIGITS multiplexed 7-segment digits.
module disp_7seg_mux #(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 100000,
  parameter bit SEG_ACT_LO = 1'b0
) (
  input  logic           clk100MHz,
  input  logic           rst,
  disp_7seg_mux_if.slave bus
);

  localparam int         CNT_W    = $clog2(SCAN_DIV);
  localparam int         IDX_W    = $clog2(DIGITS);
  localparam int         BCD_DIG  = 5;
  localparam logic [7:0] SEG_POL  = SEG_ACT_LO ? 8'hFF : 8'h00;
  localparam logic [7:0] SEG_DASH = 8'h40;
  localparam logic [7:0] SEG_DP   = 8'h80;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCALE,
    S_OFFSET,
    S_CONVERT,
    S_LOAD
  } state_t;

  // Segment pattern {g..a} for one decimal digit.
  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 8'h3F;
      4'd1:    seg_code = 8'h06;
      4'd2:    seg_code = 8'h5B;
      4'd3:    seg_code = 8'h4F;
      4'd4:    seg_code = 8'h66;
      4'd5:    seg_code = 8'h6D;
      4'd6:    seg_code = 8'h7D;
      4'd7:    seg_code = 8'h07;
      4'd8:    seg_code = 8'h7F;
      4'd9:    seg_code = 8'h6F;
      default: seg_code = 8'h00;
    endcase
  endfunction

  // Conversion datapath and FSM state.
  state_t              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [15:0]         data_q, data_d;
  logic [27:0]         prod_q, prod_d;
  logic signed [15:0]  value_q, value_d;
  logic                sign_q, sign_d;
  logic [15:0]         bin_q, bin_d;
  logic [19:0]         bcd_q, bcd_d;
  logic [3:0]          iter_q, iter_d;
  logic signed [15:0]  value_x10_q, value_x10_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [7:0]          disp_q [DIGITS];
  logic [7:0]          disp_d [DIGITS];

  // Scan state.
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [7:0]          seg_q, seg_d;

  // Per-mode scale factor and offset; mode 11 uses zero for both so the
  // arithmetic path naturally produces a zero result.
  logic [11:0]         k_sel;
  logic [15:0]         o_sel;

  // Scale/offset constants for the captured mode.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    k_sel = 12'd0;
    o_sel = 16'd0;
    case (mode_q)
      2'b00:   begin k_sel = 12'd1250; o_sel = 16'd60;  end
      2'b01:   begin k_sel = 12'd3150; o_sel = 16'd490; end
      2'b10:   begin k_sel = 12'd1750; o_sel = 16'd450; end
      default: begin k_sel = 12'd0;    o_sel = 16'd0;   end
    endcase
  end

  // Segment codes for the finished conversion, consumed in LOAD.
  logic [7:0] codes [DIGITS];
  logic       ovf;
  int         avail;

  // Sign, overflow and leading-zero blanking applied to the BCD result.
  always_comb begin
    avail = sign_q ? DIGITS - 1 : DIGITS;
    ovf   = 1'b0;
    for (int n = 0; n < BCD_DIG; n++) begin
      if (n >= avail && bcd_q[4*n +: 4] != 4'd0) ovf = 1'b1;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (mode_q == 2'b11 || ovf) begin
        codes[i] = SEG_DASH;
      end else if (sign_q && i == DIGITS - 1) begin
        codes[i] = SEG_DASH;
      end else if (i >= 2 && (bcd_q >> (4 * i)) == 20'd0) begin
        codes[i] = 8'h00;
      end else begin
        codes[i] = seg_code(bcd_q[4*i +: 4]) | ((i == 1) ? SEG_DP : 8'h00);
      end
    end
  end

  logic signed [15:0] diff_v;
  logic [19:0]        bcd_adj;

  // Next-state logic for the conversion FSM and its datapath.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    data_d      = data_q;
    prod_d      = prod_q;
    value_d     = value_q;
    sign_d      = sign_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    iter_d      = iter_q;
    value_x10_d = value_x10_q;
    error_d     = error_q;
    done_d      = 1'b0;
    disp_d      = disp_q;
    diff_v      = $signed({4'b0000, prod_q[27:16]}) - $signed(o_sel);
    bcd_adj     = bcd_q;
    for (int n = 0; n < BCD_DIG; n++) begin
      if (bcd_q[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mode_d  = bus.mode;
          data_d  = bus.data_in;
          state_d = S_SCALE;
        end
      end
      S_SCALE: begin
        prod_d  = 28'(k_sel) * 28'(data_q);
        state_d = S_OFFSET;
      end
      S_OFFSET: begin
        value_d = diff_v;
        sign_d  = diff_v[15];
        bin_d   = diff_v[15] ? 16'(-diff_v) : 16'(diff_v);
        bcd_d   = 20'd0;
        iter_d  = 4'd0;
        state_d = S_CONVERT;
      end
      S_CONVERT: begin
        {bcd_d, bin_d} = {bcd_adj[18:0], bin_q, 1'b0};
        iter_d         = iter_q + 4'd1;
        if (iter_q == 4'd15) state_d = S_LOAD;
      end
      S_LOAD: begin
        disp_d      = codes;
        value_x10_d = value_q;
        error_d     = (mode_q == 2'b11);
        done_d      = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Conversion FSM registers and registered status outputs.
  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= 2'b00;
      data_q      <= 16'd0;
      prod_q      <= 28'd0;
      value_q     <= 16'sd0;
      sign_q      <= 1'b0;
      bin_q       <= 16'd0;
      bcd_q       <= 20'd0;
      iter_q      <= 4'd0;
      value_x10_q <= 16'sd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      // NOTE: the display array is a few flops, not a RAM, so it is reset
      // to blank along with everything else.
      disp_q      <= '{default: 8'h00};
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q     <= state_d;
      mode_q      <= mode_d;
      data_q      <= data_d;
      prod_q      <= prod_d;
      value_q     <= value_d;
      sign_q      <= sign_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      iter_q      <= iter_d;
      value_x10_q <= value_x10_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      disp_q      <= disp_d;
    end
  end

  // Free-running digit scan: dwell counter, digit index, registered drive.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    an_d  = ~(DIGITS'(1) << idx_q);
    seg_d = disp_q[idx_q] ^ SEG_POL;
  end

  // Scan registers; outputs lag the index by one edge so the first edge
  // after reset already drives digit 0.
  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      an_q  <= '1;
      seg_q <= SEG_POL;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;
  assign bus.value_x10 = value_x10_q;
  assign bus.seg_out   = seg_q;
  assign bus.an_out    = an_q;

endmodule

// File: tb/tb_disp_7seg_mux.sv
// Bench for disp_7seg_mux: a 4-digit and a 3-digit instance run the same
// conversions; results are compared against fixed vectors and a decimal model.
module tb_disp_7seg_mux;

  logic        clk100MHz = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] data;

  int checks = 0;
  int errors = 0;
  bit prev_err = 1'b0;

  always #5 clk100MHz = ~clk100MHz;

  disp_7seg_mux_if #(.DIGITS(4)) bus4 ();
  disp_7seg_mux_if #(.DIGITS(3)) bus3 ();

  assign bus4.start   = start;
  assign bus4.mode    = mode;
  assign bus4.data_in = data;
  assign bus3.start   = start;
  assign bus3.mode    = mode;
  assign bus3.data_in = data;

  disp_7seg_mux #(.DIGITS(4), .SCAN_DIV(4), .SEG_ACT_LO(1'b0)) dut4 (
    .clk100MHz (clk100MHz),
    .rst       (rst),
    .bus       (bus4)
  );

  disp_7seg_mux #(.DIGITS(3), .SCAN_DIV(2), .SEG_ACT_LO(1'b0)) dut3 (
    .clk100MHz (clk100MHz),
    .rst       (rst),
    .bus       (bus3)
  );

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: tenths value straight from the scaling formula.
  function automatic int model_value(input logic [1:0] m, input logic [15:0] d);
    int k, o;
    case (m)
      2'b00:   begin k = 1250; o = 60;  end
      2'b01:   begin k = 3150; o = 490; end
      2'b10:   begin k = 1750; o = 450; end
      default: return 0;
    endcase
    return (k * int'(d)) / 65536 - o;
  endfunction

  function automatic logic [7:0] digit_seg(input int d);
    case (d)
      0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
      4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h07;
      8: return 8'h7F;  default: return 8'h6F;
    endcase
  endfunction

  // Reference: what a human reads on an nd-digit display for value v (tenths).
  function automatic logic [39:0] model_disp(input int v, input bit err, input int nd);
    logic [39:0] r = '0;
    int mag   = (v < 0) ? -v : v;
    int avail = (v < 0) ? nd - 1 : nd;
    int lim   = 1;
    int pw    = 1;
    logic [7:0] c;
    for (int j = 0; j < avail; j++) lim = lim * 10;
    for (int i = 0; i < nd; i++) begin
      if (err || mag >= lim)           c = 8'h40;
      else if (v < 0 && i == nd - 1)   c = 8'h40;
      else if (i >= 2 && mag < pw)     c = 8'h00;
      else c = digit_seg((mag / pw) % 10) | ((i == 1) ? 8'h80 : 8'h00);
      r[8*i +: 8] = c;
      pw = pw * 10;
    end
    return r;
  endfunction

  // One conversion on both instances: latency, busy window, ignored restart,
  // result, error flag and the scanned display contents.
  task automatic run_txn(input string tag, input logic [1:0] m, input logic [15:0] d,
                         input bit inject, input int exp_v, input bit exp_e,
                         input logic [39:0] exp_d4);
    int n_done4 = 0, n_done3 = 0, cyc4 = -1, cyc3 = -1;
    logic [39:0] cap4 = '0, cap3 = '0;
    logic [3:0]  seen4 = '0;
    logic [2:0]  seen3 = '0;
    @(negedge clk100MHz);
    start = 1'b1; mode = m; data = d;
    @(negedge clk100MHz);
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clk100MHz);
      if (inject && c == 10) begin start = 1'b1; mode = 2'b00; data = ~d; end
      if (inject && c == 11) start = 1'b0;
      if (bus4.done) begin n_done4++; if (cyc4 < 0) cyc4 = c; end
      if (bus3.done) begin n_done3++; if (cyc3 < 0) cyc3 = c; end
      if (c == 1)  check({tag, " busy_c1"}, 40'(bus4.busy), 40'd1);
      if (c == 19) begin
        check({tag, " busy_c19"}, 40'(bus4.busy), 40'd1);
        check({tag, " err_hold"}, 40'(bus4.error), 40'(prev_err));
      end
      if (c == 20) check({tag, " busy_c20"}, 40'(bus4.busy), 40'd0);
      if (c >= 21) begin
        for (int i = 0; i < 4; i++)
          if (!bus4.an_out[i]) begin cap4[8*i +: 8] = bus4.seg_out; seen4[i] = 1'b1; end
        for (int i = 0; i < 3; i++)
          if (!bus3.an_out[i]) begin cap3[8*i +: 8] = bus3.seg_out; seen3[i] = 1'b1; end
      end
    end
    check({tag, " done_cyc4"}, 40'(cyc4), 40'd20);
    check({tag, " done_cnt4"}, 40'(n_done4), 40'd1);
    check({tag, " done_cyc3"}, 40'(cyc3), 40'd20);
    check({tag, " done_cnt3"}, 40'(n_done3), 40'd1);
    check({tag, " value4"}, 40'(16'(bus4.value_x10)), 40'(16'(exp_v)));
    check({tag, " value3"}, 40'(16'(bus3.value_x10)), 40'(16'(exp_v)));
    check({tag, " error4"}, 40'(bus4.error), 40'(exp_e));
    check({tag, " error3"}, 40'(bus3.error), 40'(exp_e));
    check({tag, " seen"}, 40'({seen4, seen3}), 40'h7F);
    check({tag, " disp4"}, cap4, exp_d4);
    check({tag, " disp3"}, cap3, model_disp(exp_v, exp_e, 3));
    prev_err = exp_e;
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] data;
    bit          inject;
    int          value;
    bit          err;
    logic [31:0] disp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    // Expected display packed {d3,d2,d1,d0}.
    vecs[0] = '{2'b10, 16'h6666, 1'b0,  249, 1'b0, 32'h005BE66F}; // " 24.9"
    vecs[1] = '{2'b00, 16'h0000, 1'b0,  -60, 1'b0, 32'h4000FD3F}; // "- 6.0"
    vecs[2] = '{2'b01, 16'hFFFF, 1'b0, 2659, 1'b0, 32'h5B7DED6F}; // "265.9"
    vecs[3] = '{2'b11, 16'h1234, 1'b0,    0, 1'b1, 32'h40404040}; // "----"
    vecs[4] = '{2'b10, 16'h6666, 1'b1,  249, 1'b0, 32'h005BE66F}; // restart ignored, error clears
    vecs[5] = '{2'b01, 16'h0000, 1'b0, -490, 1'b0, 32'h4066EF3F}; // "-49.0"
    vecs[6] = '{2'b10, 16'h41D5, 1'b0,    0, 1'b0, 32'h0000BF3F}; // "  0.0"
    vecs[7] = '{2'b10, 16'h41D4, 1'b0,   -1, 1'b0, 32'h4000BF06}; // "- 0.1"

    start = 1'b0; mode = 2'b00; data = 16'h0000;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst busy",  40'(bus4.busy), 40'd0);
    check("rst done",  40'(bus4.done), 40'd0);
    check("rst error", 40'(bus4.error), 40'd0);
    check("rst value", 40'(16'(bus4.value_x10)), 40'd0);
    check("rst an4",   40'(bus4.an_out), 40'hF);
    check("rst seg4",  40'(bus4.seg_out), 40'h00);
    check("rst an3",   40'(bus3.an_out), 40'h7);
    repeat (3) @(negedge clk100MHz);
    rst = 1'b0;

    // Scan order and dwell with a blank display.
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk100MHz);
      check($sformatf("scan4 k%0d", k), 40'({bus4.an_out, bus4.seg_out}),
            40'({~(4'b0001 << (((k - 1) / 4) % 4)), 8'h00}));
      check($sformatf("scan3 k%0d", k), 40'({bus3.an_out, bus3.seg_out}),
            40'({~(3'b001 << (((k - 1) / 2) % 3)), 8'h00}));
    end

    for (int v = 0; v < 8; v++)
      run_txn($sformatf("vec%0d", v), vecs[v].mode, vecs[v].data, vecs[v].inject,
              vecs[v].value, vecs[v].err, 40'(vecs[v].disp));

    for (int r = 0; r < 25; r++) begin
      logic [1:0]  m;
      logic [15:0] d;
      int          ev;
      m  = 2'($urandom_range(0, 3));
      d  = 16'($urandom);
      ev = model_value(m, d);
      run_txn($sformatf("rnd%0d", r), m, d, 1'b0, ev, (m == 2'b11),
              model_disp(ev, (m == 2'b11), 4));
    end

    // Reset in the middle of CONVERT aborts the conversion and blanks the display.
    begin
      int n_done = 0, n_lit = 0, n_busy = 0;
      @(negedge clk100MHz);
      start = 1'b1; mode = 2'b10; data = 16'h6666;
      @(negedge clk100MHz);
      start = 1'b0;
      repeat (8) @(negedge clk100MHz);
      check("pre_rst busy", 40'(bus4.busy), 40'd1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst busy",  40'(bus4.busy), 40'd0);
      check("mid_rst done",  40'(bus4.done), 40'd0);
      check("mid_rst value", 40'(16'(bus4.value_x10)), 40'd0);
      check("mid_rst an4",   40'(bus4.an_out), 40'hF);
      check("mid_rst seg4",  40'(bus4.seg_out), 40'h00);
      @(negedge clk100MHz);
      rst = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk100MHz);
        if (bus4.done || bus3.done) n_done++;
        if (bus4.busy) n_busy++;
        if (bus4.seg_out != 8'h00 || bus3.seg_out != 8'h00) n_lit++;
      end
      check("post_rst no_done", 40'(n_done), 40'd0);
      check("post_rst no_busy", 40'(n_busy), 40'd0);
      check("post_rst blank",   40'(n_lit), 40'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
